hamming_secded_dec: RTL

HAMMING_SECDED_DEC -- requirements
Module: hamming_secded_dec

---
 rtl/hamming_pkg.sv | 39 +++
 rtl/hamming_syndrome.sv | 26 ++
 rtl/hamming_secded_dec.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/hamming_pkg.sv
// Shared constants, helpers and error-class enum for the SECDED Hamming decoder.
package hamming_pkg;

    typedef enum logic [1:0] {
        CLEAN = 2'd0,
        SEC   = 2'd1,
        DED   = 2'd2
    } err_class_e;

    // Smallest p with 2^p >= data_w + p + 1.
    function automatic int calc_par_w(input int data_w);
        int res;
        res = 0;
        for (int p = 1; p < 8; p++) begin
            if (res == 0 && (1 << p) >= data_w + p + 1) begin
                res = p;
            end
        end
        return res;
    endfunction

    // 1-based Hamming position of data bit idx (skips power-of-two positions).
    function automatic int data_pos(input int idx);
        int cnt;
        int res;
        cnt = 0;
        res = 0;
        for (int pos = 1; pos < 128; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (cnt == idx && res == 0) begin
                    res = pos;
                end
                cnt++;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome and overall-parity generator for a SECDED codeword.
module hamming_syndrome
    import hamming_pkg::*;
#(
    parameter  int DATA_W = 4,
    localparam int PAR_W  = calc_par_w(DATA_W),
    localparam int CODE_W = DATA_W + PAR_W + 1
) (
    input  logic [CODE_W-1:0] code_i,
    output logic [PAR_W-1:0]  syndrome_o,
    output logic              p_all_o
);

    always_comb begin
        syndrome_o = '0;
        for (int pos = 1; pos < CODE_W; pos++) begin
            for (int k = 0; k < PAR_W; k++) begin
                if (((pos >> k) & 1) == 1) begin
                    syndrome_o[k] = syndrome_o[k] ^ code_i[pos-1];
                end
            end
        end
        p_all_o = ^code_i;
    end

endmodule

// File: rtl/hamming_secded_dec.sv
// Two-stage SECDED Hamming decoder with valid/ready flow control and
// saturating single/double error counters.
module hamming_secded_dec
    import hamming_pkg::*;
#(
    parameter  int DATA_W = 4,
    parameter  int CNT_W  = 16,
    localparam int PAR_W  = calc_par_w(DATA_W),
    localparam int CODE_W = DATA_W + PAR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CODE_W-1:0] code_i,
    input  logic              corr_en_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [PAR_W-1:0]  syndrome_o,
    output logic              sec_o,
    output logic              ded_o,
    output logic [CNT_W-1:0]  sec_cnt_o,
    output logic [CNT_W-1:0]  ded_cnt_o,
    input  logic              clr_cnt_i
);

    logic              advance;
    logic              xfer;
    logic [PAR_W-1:0]  syn_in;
    logic              pall_in;

    logic              s1_valid_q, s1_valid_d;
    logic [CODE_W-1:0] s1_code_q,  s1_code_d;
    logic              s1_corr_q,  s1_corr_d;
    logic [PAR_W-1:0]  s1_syn_q,   s1_syn_d;
    logic              s1_pall_q,  s1_pall_d;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] data_q,      data_d;
    logic [PAR_W-1:0]  syn_q,       syn_d;
    logic              sec_q,       sec_d;
    logic              ded_q,       ded_d;
    logic [CNT_W-1:0]  sec_cnt_q,   sec_cnt_d;
    logic [CNT_W-1:0]  ded_cnt_q,   ded_cnt_d;

    err_class_e        err_class;
    logic              do_flip;
    logic [DATA_W-1:0] dec_data;
    logic              unused_code;

    hamming_syndrome #(.DATA_W(DATA_W)) u_syndrome (
        .code_i     (code_i),
        .syndrome_o (syn_in),
        .p_all_o    (pall_in)
    );

    assign advance    = !out_valid_q || out_ready_i;
    assign in_ready_o = advance;
    assign xfer       = out_valid_q && out_ready_i;

    always_comb begin
        err_class = CLEAN;
        if (s1_pall_q) begin
            if (int'(s1_syn_q) < CODE_W) begin
                err_class = SEC;
            end else begin
                err_class = DED;
            end
        end else if (s1_syn_q != '0) begin
            err_class = DED;
        end
    end

    assign do_flip = (err_class == SEC) && s1_corr_q;

    // Syndrome 0 with p_all set points at the overall parity bit, so no data bit flips.
    for (genvar g = 0; g < DATA_W; g++) begin : g_extract
        localparam int POS = data_pos(g);
        assign dec_data[g] = s1_code_q[POS-1] ^ (do_flip && (s1_syn_q == PAR_W'(POS)));
    end

    // Parity positions are only consumed through the registered syndrome and p_all.
    assign unused_code = ^s1_code_q;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_code_d   = s1_code_q;
        s1_corr_d   = s1_corr_q;
        s1_syn_d    = s1_syn_q;
        s1_pall_d   = s1_pall_q;
        out_valid_d = out_valid_q;
        data_d      = data_q;
        syn_d       = syn_q;
        sec_d       = sec_q;
        ded_d       = ded_q;
        if (advance) begin
            s1_valid_d  = in_valid_i;
            s1_code_d   = code_i;
            s1_corr_d   = corr_en_i;
            s1_syn_d    = syn_in;
            s1_pall_d   = pall_in;
            out_valid_d = s1_valid_q;
            data_d      = dec_data;
            syn_d       = s1_syn_q;
            sec_d       = s1_valid_q && (err_class == SEC);
            ded_d       = s1_valid_q && (err_class == DED);
        end
    end

    always_comb begin
        sec_cnt_d = sec_cnt_q;
        ded_cnt_d = ded_cnt_q;
        if (clr_cnt_i) begin
            sec_cnt_d = '0;
            ded_cnt_d = '0;
        end else begin
            if (xfer && sec_q && (sec_cnt_q != '1)) begin
                sec_cnt_d = sec_cnt_q + CNT_W'(1);
            end
            if (xfer && ded_q && (ded_cnt_q != '1)) begin
                ded_cnt_d = ded_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_code_q   <= '0;
            s1_corr_q   <= 1'b0;
            s1_syn_q    <= '0;
            s1_pall_q   <= 1'b0;
            out_valid_q <= 1'b0;
            data_q      <= '0;
            syn_q       <= '0;
            sec_q       <= 1'b0;
            ded_q       <= 1'b0;
            sec_cnt_q   <= '0;
            ded_cnt_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_code_q   <= s1_code_d;
            s1_corr_q   <= s1_corr_d;
            s1_syn_q    <= s1_syn_d;
            s1_pall_q   <= s1_pall_d;
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            syn_q       <= syn_d;
            sec_q       <= sec_d;
            ded_q       <= ded_d;
            sec_cnt_q   <= sec_cnt_d;
            ded_cnt_q   <= ded_cnt_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign data_o      = data_q;
    assign syndrome_o  = syn_q;
    assign sec_o       = sec_q;
    assign ded_o       = ded_q;
    assign sec_cnt_o   = sec_cnt_q;
    assign ded_cnt_o   = ded_cnt_q;

endmodule
